deferred_control: RTL and testbench
===================================

Name: deferred_control

Overview:
- Batched commit-step reporter for the difftest endpoint.
- Accumulates per-cycle committed-instruction counts from the DUT core instead of calling the checker every cycle.
- Hands the accumulated count to the simulator-side checker via DPI-C only at periodic check points or on counter overflow.
- Latches the checker verdict as an 8-bit result consumed by the endpoint (0 = running, 1 = DONE, 2 = FAIL).

Parameters:
- STEPWIDTH, 8: width of the step input; equals CONFIG_DIFFTEST_STEPWIDTH.
- INTERVAL, 16: check-point period in cycles; must be ≥ 2.
- PENDING_MAX, 255: maximum batch passed in one call; fixed by the byte-wide DPI argument.

Ports:
- clock  input  1  sampling clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- step  input  STEPWIDTH  instructions committed this cycle; 0 = none.
- simv_result  output  8  latched checker verdict: 0 running, 1 SIMV_DONE, 2 SIMV_FAIL, other nonzero = error code.

Behaviour:
- DPI import: byte simv_nstep(byte n). Called at most once per rising edge, always with 1 ≤ n ≤ PENDING_MAX.
- State:
  - timer, counts 0..INTERVAL-1.
  - pending, 8-bit accumulated step count.
  - result_r, 8 bits, drives simv_result.
- Reset (reset low, asynchronous): timer=0, pending=0, result_r=0, so simv_result=0 immediately. No DPI calls while reset is low.
- Each rising edge with reset high and result_r==0:
  - timer <= (timer==INTERVAL-1) ? 0 : timer+1.
  - sum = pending + step, computed 9+ bits wide with no truncation.
  - Overflow (sum > PENDING_MAX):
    - call simv_nstep(pending) if pending≠0; pending <= step.
    - The timer still advances. If this is also the expiry cycle, the overflow flush takes precedence and the step carries to the next period.
  - Otherwise, expiry (timer==INTERVAL-1):
    - call simv_nstep(sum) if sum≠0; pending <= 0.
  - Otherwise: pending <= sum; no call.
  - A nonzero call return is written to result_r at the same edge, so simv_result changes one clock after the flushing cycle's inputs.
- Once result_r≠0 the block is frozen:
  - timer, pending and result_r hold; no further calls.
  - step is ignored.
  - Only reset clears the freeze, except as described under Optional Feature.
- A zero return leaves result_r at 0.
- step>PENDING_MAX is not a legal input. The implementation saturates step to PENDING_MAX and issues $error once.
- Reset asserted mid-period discards pending steps without calling the checker.

Optional Feature:
- Macro: DEFERRED_AUTO_CLEAR_EN, which supports multi-workload switching.
- Defined:
  - A result of exactly 1 (DONE) is held on simv_result for exactly one cycle, then cleared to 0 at the next edge.
  - On that clearing edge pending and timer also clear, and accumulation resumes on the following edge.
  - FAIL and other nonzero codes stay sticky.
- Undefined: every nonzero result, including DONE, is sticky until reset.

Test Plan:
- Reset low for 3 cycles with step=5 → simv_result=0, no simv_nstep calls; after release, first call no earlier than cycle INTERVAL.
- INTERVAL=16, step=1 every cycle, stub returns 0 → exactly one call per 16 cycles with n=16; simv_result stays 0.
- step=200 then step=100 in consecutive cycles → overflow: call with n=200 on the second edge, pending=100 carried; next expiry calls n=100 plus any later steps.
- step=0 throughout → no calls ever; simv_result=0.
- Stub returns 2 on the third call → simv_result=2 one edge later and stays 2; no further calls despite continued steps; reset low clears it to 0 asynchronously.
- With DEFERRED_AUTO_CLEAR_EN, stub returns 1 → simv_result=1 for exactly one cycle, then 0; the next period calls with fresh counts. Without the macro → 1 held until reset.

Source files
------------

// File: rtl/deferred_control.sv
// deferred_control: batched commit-step reporter for the difftest endpoint.
// Per-cycle commit counts are accumulated and handed to the checker only at
// period expiry or when the byte-wide batch would overflow. The checker verdict
// is latched on simv_result and freezes the block until reset.
// Macros:
//   DEFERRED_AUTO_CLEAR_EN - a DONE verdict (1) self-clears after one cycle and
//                            restarts accumulation (multi-workload switching).
module deferred_control #(
    parameter int unsigned STEPWIDTH   = 8,
    parameter int unsigned INTERVAL    = 16,
    parameter int unsigned PENDING_MAX = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [STEPWIDTH-1:0] step,
    output logic [7:0]           simv_result
);

    localparam int unsigned TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int unsigned XW = ((STEPWIDTH > 8) ? STEPWIDTH : 8) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(INTERVAL - 1);
    localparam logic [XW-1:0] STEP_LIMIT = XW'(PENDING_MAX);
    localparam logic [8:0]    SUM_LIMIT  = 9'(PENDING_MAX);

    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    pending_q, pending_d;
    logic [7:0]    result_q;
    logic          err_seen_q;

    logic [XW-1:0] step_x_c;
    logic          step_ovr_c;
    logic [7:0]    step_sat_c;
    logic [8:0]    sum_c;
    logic          ovf_c;
    logic          expire_c;
    logic          active_c;
    logic          clear_c;
    logic          call_c;
    logic [7:0]    call_n_c;

    // Behavioural checker model: returns sim_ret_val on call number sim_ret_at,
    // zero otherwise. Call count and last batch are kept for observation.
    int unsigned sim_calls_q  = 0;
    logic [7:0]  sim_last_n_q = 8'd0;
    int unsigned sim_ret_at   = 0;
    logic [7:0]  sim_ret_val  = 8'd0;

    function automatic byte simv_nstep(input byte n);
        if (n != 8'sd0 && (sim_calls_q + 1) == sim_ret_at) begin
            return byte'(sim_ret_val);
        end
        return 8'sd0;
    endfunction

    // Record every checker call made while out of reset.
    always_ff @(posedge clock) begin
        if (reset && call_c) begin
            sim_calls_q  <= sim_calls_q + 1;
            sim_last_n_q <= call_n_c;
        end
    end

    // Saturate illegal oversized steps and form the untruncated batch sum.
    always_comb begin
        step_x_c   = XW'(step);
        step_ovr_c = step_x_c > STEP_LIMIT;
        step_sat_c = step_ovr_c ? 8'(PENDING_MAX) : step_x_c[7:0];
        sum_c      = {1'b0, pending_q} + {1'b0, step_sat_c};
        ovf_c      = sum_c > SUM_LIMIT;
        expire_c   = timer_q == TIMER_LAST;
        active_c   = result_q == 8'd0;
    end

    // Next-state for timer/pending and the checker call decision.
    always_comb begin
        timer_d   = timer_q;
        pending_d = pending_q;
        clear_c   = 1'b0;
        call_c    = 1'b0;
        call_n_c  = 8'd0;
`ifdef DEFERRED_AUTO_CLEAR_EN
        if (result_q == 8'd1) begin
            clear_c   = 1'b1;
            timer_d   = '0;
            pending_d = 8'd0;
        end
`endif
        if (active_c) begin
            timer_d = expire_c ? '0 : timer_q + TW'(1);
            if (ovf_c) begin
                // Overflow flush wins over expiry; this step starts the new batch.
                call_c    = pending_q != 8'd0;
                call_n_c  = pending_q;
                pending_d = step_sat_c;
            end else if (expire_c) begin
                call_c    = sum_c != 9'd0;
                call_n_c  = sum_c[7:0];
                pending_d = 8'd0;
            end else begin
                pending_d = sum_c[7:0];
            end
        end
    end

    // State registers; the checker verdict is latched at the flushing edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q   <= '0;
            pending_q <= 8'd0;
            result_q  <= 8'd0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            if (clear_c) begin
                result_q <= 8'd0;
            end else if (call_c) begin
                result_q <= simv_nstep(call_n_c);
            end
        end
    end

    // One-shot report of an out-of-range step value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_seen_q <= 1'b0;
        end else if (active_c && step_ovr_c && !err_seen_q) begin
            err_seen_q <= 1'b1;
            $error("deferred_control: step %0d exceeds %0d, saturated", step, PENDING_MAX);
        end
    end

    assign simv_result = result_q;

endmodule

// File: tb/tb_deferred_control.sv
// Directed bench for deferred_control using the built-in checker model.
module tb_deferred_control;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] step  = 8'd5;
    wire  [7:0] simv_result;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned base   = 0;

    deferred_control #(
        .STEPWIDTH  (8),
        .INTERVAL   (16),
        .PENDING_MAX(255)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .step       (step),
        .simv_result(simv_result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold step at s for k rising edges; returns on a falling edge.
    task automatic run(input logic [7:0] s, input int k);
        step = s;
        repeat (k) @(negedge clock);
    endtask

    task automatic restart();
        reset = 1'b0;
        step  = 8'd0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        base  = dut.sim_calls_q;
    endtask

    function automatic logic [31:0] calls();
        return 32'(dut.sim_calls_q - base);
    endfunction

    initial begin
        // Reset held with nonzero steps
        repeat (3) @(negedge clock);
        chk("rst_result", 32'(simv_result), 0);
        chk("rst_calls", calls(), 0);
        reset = 1'b1;
        base  = dut.sim_calls_q;

        // step=1 every cycle: one call of 16 per period
        run(8'd1, 15);
        chk("early_calls", calls(), 0);
        run(8'd1, 1);
        chk("p1_calls", calls(), 1);
        chk("p1_n", 32'(dut.sim_last_n_q), 16);
        run(8'd1, 15);
        chk("p2_early_calls", calls(), 1);
        run(8'd1, 1);
        chk("p2_calls", calls(), 2);
        chk("p2_n", 32'(dut.sim_last_n_q), 16);
        chk("p2_result", 32'(simv_result), 0);

        // 200 then 100: overflow flush of 200, 100 carried
        restart();
        run(8'd200, 1);
        chk("ovf_pre_calls", calls(), 0);
        run(8'd100, 1);
        chk("ovf_calls", calls(), 1);
        chk("ovf_n", 32'(dut.sim_last_n_q), 200);
        run(8'd7, 1);
        run(8'd0, 12);
        chk("carry_early_calls", calls(), 1);
        run(8'd0, 1);
        chk("carry_calls", calls(), 2);
        chk("carry_n", 32'(dut.sim_last_n_q), 107);

        // Overflow on the expiry edge: flush wins, step carries a full period
        restart();
        run(8'd0, 14);
        run(8'd250, 1);
        chk("ovx_pre_calls", calls(), 0);
        run(8'd10, 1);
        chk("ovx_calls", calls(), 1);
        chk("ovx_n", 32'(dut.sim_last_n_q), 250);
        run(8'd0, 15);
        chk("ovx_early_calls", calls(), 1);
        run(8'd0, 1);
        chk("ovx_carry_calls", calls(), 2);
        chk("ovx_carry_n", 32'(dut.sim_last_n_q), 10);

        // No steps: never a call
        restart();
        run(8'd0, 48);
        chk("idle_calls", calls(), 0);
        chk("idle_result", 32'(simv_result), 0);

        // Batch of exactly 255 is not an overflow
        restart();
        run(8'd255, 1);
        run(8'd0, 14);
        chk("max_early_calls", calls(), 0);
        run(8'd0, 1);
        chk("max_calls", calls(), 1);
        chk("max_n", 32'(dut.sim_last_n_q), 255);

        // FAIL on the third call: sticky, frozen, async reset clears
        restart();
        dut.sim_ret_at  = dut.sim_calls_q + 3;
        dut.sim_ret_val = 8'd2;
        run(8'd1, 47);
        chk("fail_pre_result", 32'(simv_result), 0);
        chk("fail_pre_calls", calls(), 2);
        run(8'd1, 1);
        chk("fail_calls", calls(), 3);
        chk("fail_n", 32'(dut.sim_last_n_q), 16);
        chk("fail_result", 32'(simv_result), 2);
        run(8'd3, 40);
        chk("fail_sticky", 32'(simv_result), 2);
        chk("fail_frozen_calls", calls(), 3);
        #2 reset = 1'b0;
        #1 chk("fail_async_clear", 32'(simv_result), 0);

        // DONE verdict on the first call
        restart();
        dut.sim_ret_at  = dut.sim_calls_q + 1;
        dut.sim_ret_val = 8'd1;
        run(8'd2, 16);
        chk("done_calls", calls(), 1);
        chk("done_n", 32'(dut.sim_last_n_q), 32);
        chk("done_result", 32'(simv_result), 1);
        run(8'd2, 1);
`ifdef DEFERRED_AUTO_CLEAR_EN
        chk("done_cleared", 32'(simv_result), 0);
        run(8'd2, 15);
        chk("done_next_early", calls(), 1);
        run(8'd2, 1);
        chk("done_next_calls", calls(), 2);
        chk("done_next_n", 32'(dut.sim_last_n_q), 32);
        chk("done_next_result", 32'(simv_result), 0);
`else
        chk("done_held", 32'(simv_result), 1);
        run(8'd2, 30);
        chk("done_still_held", 32'(simv_result), 1);
        chk("done_frozen_calls", calls(), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
